// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor: counter encoding,
// default BTB depth and the saturating counter step.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  localparam int BP_ENTRIES_DEFAULT = 64;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e cur, input logic taken);
    bp_ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != BP_ST) nxt = bp_ctr_e'(cur + 2'd1);
    end else begin
      if (cur != BP_SNT) nxt = bp_ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_perf_cnt.sv
// 32-bit event counter with async active-low reset, synchronous clear and
// enable; clear wins over a same-cycle increment, and the count wraps.
module bp_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational next-PC
// prediction in IF, training and mispredict redirect from the EX result.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = BP_ENTRIES_DEFAULT,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_br,
  input  logic [31:0] ex_br_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        perf_clr,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  bp_ctr_e            ctr_mem [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;

  // Byte offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  assign if_hit      = valid[if_idx] && (tag_mem[if_idx] == if_tag);
  assign ex_hit      = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
  assign pred_taken  = if_hit && ctr_mem[if_idx][1];
  assign pred_target = pred_taken ? tgt_mem[if_idx] : (if_pc + 32'd4);

  assign mispredict  = upd_valid &&
                       ((ex_pred_taken != ex_br) ||
                        (ex_br && (ex_pred_target != ex_br_target)));
  assign redirect_pc = ex_br ? ex_br_target : (ex_pc + 32'd4);

  // Only valid bits are reset; everything else is don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (upd_valid && ex_br && !ex_hit) begin
      valid[ex_idx] <= 1'b1;
    end
  end

  // Not-taken misses leave the entry alone so a live alias is not evicted.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (ex_hit) begin
        ctr_mem[ex_idx] <= bp_ctr_next(ctr_mem[ex_idx], ex_br);
        if (ex_br) tgt_mem[ex_idx] <= ex_br_target;
      end else if (ex_br) begin
        tag_mem[ex_idx] <= ex_tag;
        tgt_mem[ex_idx] <= ex_br_target;
        ctr_mem[ex_idx] <= BP_WT;
      end
    end
  end

  bp_perf_cnt u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .en    (upd_valid),
    .count (br_count)
  );

  bp_perf_cnt u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .en    (mispredict),
    .count (miss_count)
  );

endmodule
